// File: rtl/udp_gen_pkg.sv
// Shared types and widths for the UDP generator scheduler.
package udp_gen_pkg;

    localparam int MAC_W  = 48;
    localparam int IPV4_W = 32;
    localparam int PORT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_BUSY,
        ST_GAP
    } sched_state_t;

    typedef struct packed {
        logic [MAC_W-1:0]  dst_mac;
        logic [IPV4_W-1:0] dst_ipv4;
        logic [PORT_W-1:0] src_port;
        logic [PORT_W-1:0] dst_port;
    } hdr_fields_t;

endpackage

// File: rtl/axis_udp_gen_sched_arb.sv
// Round-robin arbiter: the search starts one past the last granted index,
// and the pointer moves only when a grant is actually taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Pick the first requester after last_idx, wrapping around once
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // Remember the winner so the next search begins after it
    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx <= IDX_W'(NUM_REQ - 1);
        end else if (advance && found) begin
            last_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/axis_udp_gen_sched.sv
// Frame scheduler in front of a UDP generator: arbitrates requesters,
// loads header fields, starts the generator, waits for the frame's last
// beat and enforces an inter-frame gap.
// Optional watchdog on BUSY enabled by defining UDP_GEN_SCHED_TIMEOUT_EN.
module axis_udp_gen_sched
    import udp_gen_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       axis_clk,
    input  logic                       axis_s_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*48-1:0]      req_dst_mac,
    input  logic [NUM_REQ*32-1:0]      req_dst_ipv4,
    input  logic [NUM_REQ*16-1:0]      req_src_port,
    input  logic [NUM_REQ*16-1:0]      req_dst_port,
    output logic [47:0]                dst_mac_addr,
    output logic [31:0]                dst_ipv4_addr,
    output logic [15:0]                src_udp_port,
    output logic [15:0]                dst_udp_port,
    output logic                       gen_start,
    input  logic                       mon_tvalid,
    input  logic                       mon_tready,
    input  logic                       mon_tlast,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [31:0]                frame_cnt
`ifdef UDP_GEN_SCHED_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // IFG of zero still spends one cycle in GAP
    localparam logic [7:0] GAP_LAST = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic [NUM_REQ-1:0] grant_q;
    logic             advance;
    logic             frame_done;
    logic             wd_expire;
    logic [7:0]       gap_cnt;
    hdr_fields_t      hdr_sel;
    hdr_fields_t      hdr_q;

    assign advance    = (state == ST_IDLE) && (|req_valid);
    assign frame_done = mon_tvalid & mon_tready & mon_tlast;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (axis_clk),
        .rst       (axis_s_rst),
        .req       (req_valid),
        .advance   (advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Slice out the winning requester's header fields
    always_comb begin
        hdr_sel          = '0;
        hdr_sel.dst_mac  = req_dst_mac[MAC_W*arb_idx +: MAC_W];
        hdr_sel.dst_ipv4 = req_dst_ipv4[IPV4_W*arb_idx +: IPV4_W];
        hdr_sel.src_port = req_src_port[PORT_W*arb_idx +: PORT_W];
        hdr_sel.dst_port = req_dst_port[PORT_W*arb_idx +: PORT_W];
    end

`ifdef UDP_GEN_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == ST_BUSY) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Count BUSY cycles and flag a frame that never finished
    always_ff @(posedge axis_clk) begin
        if (axis_s_rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= (state == ST_BUSY) ? wd_cnt + 1'b1 : '0;
            timeout_err <= wd_expire && !frame_done;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state logic; a finished frame takes priority over the watchdog
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (|req_valid) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_START;
            ST_START: state_next = ST_BUSY;
            ST_BUSY:  if (frame_done || wd_expire) state_next = ST_GAP;
            ST_GAP:   if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axis_clk) begin
        if (axis_s_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture header and grant when leaving IDLE; held until the next grant
    always_ff @(posedge axis_clk) begin
        if (axis_s_rst) begin
            hdr_q    <= '0;
            grant_id <= '0;
            grant_q  <= '0;
        end else if (advance) begin
            hdr_q    <= hdr_sel;
            grant_id <= arb_idx;
            grant_q  <= arb_grant;
        end
    end

    // Frames are counted only when the last beat really handshakes
    always_ff @(posedge axis_clk) begin
        if (axis_s_rst) begin
            frame_cnt <= '0;
        end else if (state == ST_BUSY && frame_done) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end

    // Inter-frame gap length counter
    always_ff @(posedge axis_clk) begin
        if (axis_s_rst) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 8'd1;
        end else begin
            gap_cnt <= '0;
        end
    end

    assign req_ready     = (state == ST_LOAD) ? grant_q : '0;
    assign gen_start     = (state == ST_START);
    assign busy          = (state != ST_IDLE);
    assign dst_mac_addr  = hdr_q.dst_mac;
    assign dst_ipv4_addr = hdr_q.dst_ipv4;
    assign src_udp_port  = hdr_q.src_port;
    assign dst_udp_port  = hdr_q.dst_port;

endmodule

// File: doc/axis_udp_gen_sched.md
AXIS_UDP_GEN_SCHED -- requirements
Module: axis_udp_gen_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter IFG_CYCLES, default 12, meaning idle cycles enforced between frames (0..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning watchdog limit per frame (used only under macro).
REQ-004 SHALL have port axis_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port axis_s_rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, meaning requester i wants one frame sent.
REQ-007 SHALL have port req_ready, output, NUM_REQ, meaning one-hot acceptance pulse of requester i.
REQ-008 SHALL have port req_dst_mac, input, NUM_REQ*48, meaning per-requester destination MAC, slice i at [48*i +: 48].
REQ-009 SHALL have port req_dst_ipv4, input, NUM_REQ*32, meaning per-requester destination IPv4.
REQ-010 SHALL have port req_src_port / req_dst_port, input, NUM_REQ*16 each, meaning per-requester UDP ports.
REQ-011 SHALL have ports dst_mac_addr (48), dst_ipv4_addr (32), src_udp_port (16), dst_udp_port (16), outputs, meaning registered header fields to the generator.
REQ-012 SHALL have port gen_start, output, 1, meaning one-cycle start pulse to the generator.
REQ-013 SHALL have ports mon_tvalid, mon_tready, mon_tlast, inputs, 1 each, meaning tap of the generator's AXIS master output.
REQ-014 SHALL have ports busy (1), grant_id ($clog2(NUM_REQ)), frame_cnt (32), outputs, meaning status.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> START -> BUSY -> GAP -> IDLE.
REQ-016 IDLE: if any req_valid, SHALL select by round-robin starting after the last-granted index, go to LOAD; else stay.
REQ-017 LOAD: SHALL register the granted requester's fields onto header outputs, set grant_id, pulse req_ready[grant] for exactly this cycle.
REQ-018 START: SHALL assert gen_start for exactly one cycle; header outputs SHALL be stable from LOAD until GAP exit.
REQ-019 BUSY: SHALL leave on the cycle mon_tvalid&mon_tready&mon_tlast is sampled high; beats without tlast, or tlast without handshake, SHALL be ignored.
REQ-020 On frame end SHALL increment frame_cnt (wraps 0xFFFFFFFF -> 0) and enter GAP.
REQ-021 GAP SHALL last exactly IFG_CYCLES cycles; IFG_CYCLES=0 SHALL go GAP -> IDLE after one cycle.
REQ-022 Request-to-gen_start latency SHALL be 3 cycles (IDLE sample, LOAD, START).
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 Round-robin pointer SHALL update only on grant; a requester dropping req_valid before grant SHALL lose nothing else.
REQ-025 req_valid changes during LOAD..GAP SHALL not affect the current frame.

Reset
REQ-026 During axis_s_rst SHALL force IDLE, req_ready=0, gen_start=0, busy=0, header outputs=0, grant_id=0, frame_cnt=0, RR pointer to NUM_REQ-1 (requester 0 first).
REQ-027 Reset mid-BUSY SHALL abandon the frame without counting it; the generator is reset by the same signal.

Configuration
REQ-028 With UDP_GEN_SCHED_TIMEOUT_EN defined SHALL add watchdog: BUSY exceeding TIMEOUT_CYCLES cycles SHALL go to GAP, pulse output timeout_err one cycle, not increment frame_cnt.
REQ-029 Without UDP_GEN_SCHED_TIMEOUT_EN the port timeout_err and watchdog counter SHALL not exist; BUSY waits indefinitely.

Structure
REQ-030 Shared package udp_gen_pkg SHALL hold FSM state enum, MAC/IPv4/port width constants, header-field struct type.
REQ-031 Round-robin arbiter SHALL be a sub-module rr_arbiter (NUM_REQ param, req in, one-hot grant out, advance input).

Verification
REQ-032 Single req_valid=0001, fields MAC 0x0A0B0C0D0E0F/IP 0xC0A80002/ports 1234->5678 -> req_ready[0] on cycle 2, gen_start cycle 3, outputs match.
REQ-033 req_valid=1111 held -> grants 0,1,2,3,0 in order, frame_cnt=5 after five tlast handshakes.
REQ-034 tlast with mon_tready=0 for 10 cycles then handshake -> state leaves BUSY only on handshake cycle.
REQ-035 IFG_CYCLES=12, back-to-back requests -> exactly 12 GAP cycles between tlast handshake and next LOAD; IFG_CYCLES=0 -> 1 cycle.
REQ-036 axis_s_rst asserted mid-BUSY -> next cycle all outputs at reset values, frame_cnt unchanged from 0 path, next grant requester 0.
REQ-037 Macro defined, TIMEOUT_CYCLES=64, no tlast -> timeout_err pulse after 64 BUSY cycles, frame_cnt unchanged, next grant proceeds.
